approx_mul_error_monitor: RTL and testbench

// - Downstream stage of the 8x8 unsigned approximate multipliers: consumes operands x,y and the

---
 rtl/approx_mul_error_monitor.sv | 111 +++++++++++
 tb/tb_approx_mul_error_monitor.sv | 114 +++++++++++
 2 files changed

// File: rtl/approx_mul_error_monitor.sv
// approx_mul_error_monitor: error statistics (ED sum/max/count) for an 8x8 approximate multiplier.
// Optional squared-ED accumulator enabled by defining SQ_ERR_EN.
module approx_mul_error_monitor #(
  parameter int N_SAMPLES = 4096,
  parameter int CNT_W     = 16,
  parameter int ACC_W     = 32,
  parameter int SQ_W      = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  input  logic [15:0]      z_apx,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [15:0]      ed_max,
  output logic [SQ_W-1:0]  sq_sum
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
  logic             v1_q, v1_d, v2_q, v2_d;
  logic [15:0]      exact_q, exact_d, zapx_q, zapx_d, ed_q, ed_d, ed_max_q, ed_max_d;
  logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
  logic [ACC_W:0]   ed_sum_ext;
  logic             accept, clr, last;

  assign in_ready = state_q == RUN;
  assign accept   = in_valid & in_ready;
  assign clr      = start & (state_q == IDLE || state_q == DONE);
  assign last     = accept && acc_cnt_q == CNT_W'(N_SAMPLES - 1);
  assign done     = state_q == DONE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last ? DRAIN : RUN;
      DRAIN:   state_d = (!v1_q && !v2_q) ? DONE : DRAIN;
      DONE:    state_d = start ? RUN : DONE;
      default: state_d = IDLE;
    endcase
    acc_cnt_d    = clr ? '0 : acc_cnt_q + CNT_W'(accept);
    v1_d         = accept;
    exact_d      = {8'd0, x} * {8'd0, y};
    zapx_d       = z_apx;
    v2_d         = v1_q;
    ed_d         = exact_q >= zapx_q ? exact_q - zapx_q : zapx_q - exact_q;
    ed_sum_ext   = {1'b0, ed_sum_q} + (ACC_W+1)'(ed_q);
    sample_cnt_d = clr ? '0 : v2_q ? sample_cnt_q + 1'b1 : sample_cnt_q;
    err_cnt_d    = clr ? '0 : v2_q ? err_cnt_q + CNT_W'(ed_q != 16'd0) : err_cnt_q;
    ed_max_d     = clr ? '0 : (v2_q && ed_q > ed_max_q) ? ed_q : ed_max_q;
    ed_sum_d     = clr ? '0 : !v2_q ? ed_sum_q : ed_sum_ext[ACC_W] ? '1 : ed_sum_ext[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_cnt_q    <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      exact_q      <= '0;
      zapx_q       <= '0;
      ed_q         <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      ed_max_q     <= '0;
      ed_sum_q     <= '0;
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      exact_q      <= exact_d;
      zapx_q       <= zapx_d;
      ed_q         <= ed_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ed_max_q     <= ed_max_d;
      ed_sum_q     <= ed_sum_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign ed_sum     = ed_sum_q;
  assign ed_max     = ed_max_q;

`ifdef SQ_ERR_EN
  logic [SQ_W-1:0] sq_sum_q, sq_sum_d;
  logic [SQ_W:0]   sq_ext;
  logic [31:0]     ed_sq;
  always_comb begin
    ed_sq    = {16'd0, ed_q} * {16'd0, ed_q};
    sq_ext   = {1'b0, sq_sum_q} + (SQ_W+1)'(ed_sq);
    sq_sum_d = clr ? '0 : !v2_q ? sq_sum_q : sq_ext[SQ_W] ? '1 : sq_ext[SQ_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) sq_sum_q <= '0;
    else     sq_sum_q <= sq_sum_d;
  end
  assign sq_sum = sq_sum_q;
`else
  assign sq_sum = '0;
`endif
endmodule

// File: tb/tb_approx_mul_error_monitor.sv
// tb_approx_mul_error_monitor: directed checks of run control, statistics, saturation and reset.
module tb_approx_mul_error_monitor;
  localparam int CNT_W = 16, ACC_W = 17, SQ_W = 48;
`ifdef SQ_ERR_EN
  localparam longint SQ2 = 64'd4228250650, SQ3 = 64'd16913002500;
`else
  localparam longint SQ2 = 0, SQ3 = 0;
`endif
  logic clk = 0, rst, start, in_valid, in_ready, done;
  logic [7:0] x, y;
  logic [15:0] z_apx, ed_max;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [ACC_W-1:0] ed_sum;
  logic [SQ_W-1:0] sq_sum;
  int total = 0, bad = 0;

  approx_mul_error_monitor #(.N_SAMPLES(4), .CNT_W(CNT_W), .ACC_W(ACC_W), .SQ_W(SQ_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z_apx(z_apx), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .ed_sum(ed_sum), .ed_max(ed_max), .sq_sum(sq_sum));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b, input logic [15:0] z);
    x = a; y = b; z_apx = z; in_valid = 1;
    chk("ready_before_accept", in_ready, 1);
    step();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 10) begin step(); n++; end
    chk("done_latency", n, 3);
  endtask

  task automatic chk_stats(input longint sc, input longint ec, input longint es,
                           input longint em, input longint sq);
    chk("sample_cnt", sample_cnt, sc);
    chk("err_cnt", err_cnt, ec);
    chk("ed_sum", ed_sum, es);
    chk("ed_max", ed_max, em);
    chk("sq_sum", sq_sum, sq);
  endtask

  initial begin
    rst = 1; start = 1; in_valid = 0; x = 0; y = 0; z_apx = 0;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk_stats(0, 0, 0, 0, 0);
    start = 0; rst = 0;
    step();
    chk("idle_after_rst_start", in_ready, 0);

    start = 1; step(); start = 0;
    chk("run_in_ready", in_ready, 1);
    repeat (4) feed(3, 5, 15);
    in_valid = 0;
    chk("drain_in_ready", in_ready, 0);
    chk("drain_done", done, 0);
    wait_done();
    chk_stats(4, 0, 0, 0, 0);

    start = 1; step(); start = 0;
    chk("clear_done", done, 0);
    chk("clear_ready", in_ready, 1);
    chk_stats(0, 0, 0, 0, 0);
    feed(200, 100, 19996);
    feed(2, 2, 7);
    feed(255, 255, 0);
    chk("midrun_sample_cnt", sample_cnt, 1);
    chk("midrun_ed_sum", ed_sum, 4);
    feed(0, 9, 0);
    x = 255; y = 255; z_apx = 0;
    chk("fifth_not_ready", in_ready, 0);
    wait_done();
    in_valid = 0;
    chk_stats(4, 3, 65032, 65025, SQ2);
    step(); step();
    chk("done_held", done, 1);
    chk("stable_ed_sum", ed_sum, 65032);

    start = 1; step(); start = 0;
    repeat (4) feed(255, 255, 0);
    in_valid = 0;
    wait_done();
    chk_stats(4, 4, 131071, 65025, SQ3);

    start = 1; step(); start = 0;
    feed(2, 2, 7);
    in_valid = 0;
    rst = 1; step(); rst = 0;
    chk("rst_mid_ready", in_ready, 0);
    chk_stats(0, 0, 0, 0, 0);
    step(); step();
    chk("rst_mid_discard", sample_cnt, 0);
    chk("rst_mid_idle", in_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
